// File: rtl/ppu_write_sched_if.sv
`default_nettype none
// ============================================================================
// ppu_write_sched_if : host write bus + table write port of the PPU scheduler
// Revision 1.0
// ============================================================================
interface ppu_write_sched_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          chipselect;
  logic          write;
  logic [15:0]   address;
  logic [31:0]   writedata;
  logic          waitrequest;
  logic [9:0]    vcount;
  logic [2:0]    mem_write;
  logic [15:0]   w_addr;
  logic [31:0]   w_data;
  logic [CW-1:0] pending;
  logic          drained;

  modport slave (
    input  chipselect, write, address, writedata, vcount,
    output waitrequest, mem_write, w_addr, w_data, pending, drained
  );

  modport master (
    output chipselect, write, address, writedata, vcount,
    input  waitrequest, mem_write, w_addr, w_data, pending, drained
  );
endinterface
`default_nettype wire

// File: rtl/ppu_write_sched.sv
`default_nettype none
// ============================================================================
// ppu_write_sched : queues host table writes, releases them in vertical blank
// Revision 1.0
// ============================================================================
module ppu_write_sched #(
  parameter int DEPTH   = 16,
  parameter int VACTIVE = 480,
  parameter int VTOTAL  = 525
) (
  input  wire logic         clk,
  input  wire logic         reset,
  ppu_write_sched_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);
  localparam logic [9:0]    c_vfirst     = 10'(VACTIVE);
  localparam logic [9:0]    c_vlast      = 10'(VTOTAL - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [47:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_mem_write;
  logic [15:0]   r_w_addr;
  logic [31:0]   r_w_data;
  logic          r_drained;

  logic          w_window;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [47:0]   w_head;

  // Line VTOTAL-1 is the renderer prefetch line, so the window shuts one line early.
  assign w_window = (bus.vcount >= c_vfirst) && (bus.vcount < c_vlast);
  assign w_full   = (r_count == c_full_count);
  assign w_empty  = (r_count == '0);
  assign w_push   = bus.chipselect && bus.write && !w_full;
  assign w_pop    = (r_state == S_DRAIN) && w_window && !w_empty;
  assign w_head   = r_mem[r_rd_ptr];

  assign bus.waitrequest = bus.chipselect && bus.write && w_full;
  assign bus.mem_write   = r_mem_write;
  assign bus.w_addr      = r_w_addr;
  assign bus.w_data      = r_w_data;
  assign bus.pending     = r_count;
  assign bus.drained     = r_drained;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.address, bus.writedata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_write <= 3'b000;
      r_w_addr    <= '0;
      r_w_data    <= '0;
      r_drained   <= 1'b0;
    end else begin
      r_mem_write <= 3'b000;
      r_drained   <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_w_addr <= w_head[47:32];
        r_w_data <= w_head[31:0];
        // Table select is address[9:8]; both 2 and 3 map to the sprite table.
        if (w_head[41]) begin
          r_mem_write <= 3'b100;
        end else if (w_head[40]) begin
          r_mem_write <= 3'b010;
        end else begin
          r_mem_write <= 3'b001;
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_WAIT: begin
          if (w_window) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!w_window) begin
            r_state <= S_WAIT;
          end else if (w_empty && !w_push) begin
            r_state   <= S_DONE;
            r_drained <= 1'b1;
          end
        end
        S_DONE: begin
          // A push arriving now lets the next cycle pop, keeping two-cycle latency.
          if (!w_window) begin
            r_state <= S_WAIT;
          end else if (!w_empty || w_push) begin
            r_state <= S_DRAIN;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ppu_write_sched.sv
`default_nettype none
// ============================================================================
// tb_ppu_write_sched : scoreboard bench for the PPU write scheduler
// Revision 1.0
// ============================================================================
module tb_ppu_write_sched;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  int   drains;
  int   cyc;
  int   last_acc;
  int   pulse_cyc [64];
  bit   mon_en;
  logic [50:0] exp_q [$];

  ppu_write_sched_if #(.DEPTH(DEPTH)) bus ();

  ppu_write_sched #(
    .DEPTH  (DEPTH),
    .VACTIVE(480),
    .VTOTAL (525)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] tbl_pulse(input logic [15:0] a);
    case (a[9:8])
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every table pulse must match the oldest outstanding accepted write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.drained === 1'b1) drains++;
      if (bus.mem_write !== 3'b000) begin
        pulse_cyc[pulses % 64] = cyc;
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stale_pulse actual=%0h/%0h/%0h required=none",
                   bus.mem_write, bus.w_addr, bus.w_data);
        end else begin
          logic [50:0] e;
          e = exp_q.pop_front();
          if ({bus.mem_write, bus.w_addr, bus.w_data} !== e) begin
            errors++;
            $display("FAIL pulse actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                     bus.mem_write, bus.w_addr, bus.w_data, e[50:48], e[47:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    #1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (bus.waitrequest !== 1'b0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(n), 64'(0));
    end else begin
      exp_q.push_back({tbl_pulse(bus.address), bus.address, bus.writedata});
      last_acc = cyc;
      @(posedge clk);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    drive(a, d);
    wait_accept();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.pending !== '0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0, d0, a0;
    checks = 0; errors = 0; pulses = 0; drains = 0; cyc = 0; mon_en = 1'b0;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 16'h0001;
    bus.writedata  = 32'h12345678;
    bus.vcount     = 10'd480;
    reset          = 1'b1;

    // Reset with writes held asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_write", 64'(bus.mem_write), 64'(0));
    chk("rst_w_addr", 64'(bus.w_addr), 64'(0));
    chk("rst_w_data", 64'(bus.w_data), 64'(0));
    chk("rst_pending", 64'(bus.pending), 64'(0));
    chk("rst_drained", 64'(bus.drained), 64'(0));
    chk("rst_waitrequest", 64'(bus.waitrequest), 64'(0));
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    reset          = 1'b0;
    mon_en         = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_no_push", 64'(bus.pending), 64'(0));
    chk("rst_no_pulse", 64'(pulses), 64'(0));

    // Single write outside the window, then open it.
    bus.vcount = 10'd100;
    wr(16'h0005, 32'hDEADBEEF);
    idle();
    #1;
    chk("t2_pending", 64'(bus.pending), 64'(1));
    chk("t2_no_pulse", 64'(bus.mem_write), 64'(0));
    p0 = pulses; d0 = drains;
    bus.vcount = 10'd480;
    wait_empty("t2_drain");
    repeat (4) @(negedge clk);
    #1;
    chk("t2_pulse_count", 64'(pulses - p0), 64'(1));
    chk("t2_drained_once", 64'(drains - d0), 64'(1));

    // Back-to-back writes with the window open and the FIFO empty.
    p0 = pulses;
    wr(16'h0103, 32'h11111111);
    a0 = last_acc;
    wr(16'h0200, 32'h22222222);
    wr(16'h0300, 32'h33333333);
    idle();
    wait_empty("t3_drain");
    chk("t3_pulse_count", 64'(pulses - p0), 64'(3));
    // Accept edge plus one pop edge: the first pulse is seen two edges later.
    chk("t3_latency0", 64'(pulse_cyc[p0 % 64]), 64'(a0 + 2));
    chk("t3_latency1", 64'(pulse_cyc[(p0 + 1) % 64]), 64'(a0 + 3));
    chk("t3_latency2", 64'(pulse_cyc[(p0 + 2) % 64]), 64'(a0 + 4));

    // Fill the FIFO outside the window; the extra write must stall.
    bus.vcount = 10'd10;
    p0 = pulses;
    for (int i = 0; i < DEPTH; i++) begin
      wr(16'(16'h0010 + i + ((i % 3) << 8)), 32'hA0000000 + 32'(i));
    end
    drive(16'h0377, 32'hBBBB0017);
    chk("t4_waitrequest", 64'(bus.waitrequest), 64'(1));
    chk("t4_pending_full", 64'(bus.pending), 64'(DEPTH));
    @(negedge clk);
    #1;
    chk("t4_still_stalled", 64'(bus.waitrequest), 64'(1));
    bus.vcount = 10'd480;
    wait_accept();
    idle();
    wait_empty("t4_drain");
    chk("t4_pulse_count", 64'(pulses - p0), 64'(DEPTH + 1));

    // Window closes with five entries left; they finish in the next frame.
    bus.vcount = 10'd10;
    for (int i = 0; i < 12; i++) begin
      wr(16'(16'h0040 + i + ((i % 4) << 8)), 32'hC0000000 + 32'(i));
    end
    idle();
    #1;
    p0 = pulses;
    bus.vcount = 10'd523;
    for (int n = 0; n < 100 && bus.pending !== 5'd5; n++) begin
      @(negedge clk);
      #1;
    end
    bus.vcount = 10'd524;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_pending_held", 64'(bus.pending), 64'(5));
    chk("t5_pops_stopped", 64'(pulses - p0), 64'(7));
    chk("t5_idle", 64'(bus.mem_write), 64'(0));
    bus.vcount = 10'd0;
    repeat (3) @(negedge clk);
    bus.vcount = 10'd480;
    wait_empty("t5_drain");
    chk("t5_pulse_count", 64'(pulses - p0), 64'(12));

    // Reset in the middle of a burst drain.
    bus.vcount = 10'd10;
    for (int i = 0; i < 8; i++) begin
      wr(16'(16'h0080 + i), 32'hE0000000 + 32'(i));
    end
    idle();
    bus.vcount = 10'd480;
    for (int n = 0; n < 100 && bus.pending > 5'd5; n++) begin
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_pulse_cancel", 64'(bus.mem_write), 64'(0));
    chk("t6_pending", 64'(bus.pending), 64'(0));
    exp_q.delete();
    p0 = pulses;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_stale", 64'(pulses - p0), 64'(0));
    chk("t6_pending_after", 64'(bus.pending), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
